// File: rtl/mem_stall_requester_pkg.sv
// Shared types for mem_stall_requester: FSM state encoding and default bus widths.
package mem_stall_requester_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DDONE = 2'd1,
        S_REL   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_stall_requester_timeout.sv
// bus_timeout_counter: counts bus wait cycles and flags the cycle that reaches the limit.
// Only instantiated by mem_stall_requester when BUS_TIMEOUT_EN is defined.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_i,
    output logic hit_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle that is not a wait (ack, idle, or a new phase) restarts the count.
    always_comb begin
        hit_o = wait_i && (cnt_q == CW'(TIMEOUT_CYCLES));
        cnt_d = cnt_q;
        if (!wait_i || hit_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_stall_requester.sv
// Serialises data and fetch accesses of one pipeline step onto a single memory bus,
// stalling the pipeline until both complete. Optional macro: BUS_TIMEOUT_EN.
module mem_stall_requester
    import mem_stall_requester_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_en,
    input  logic [ADDR_WIDTH-1:0]   inst_addr,
    output logic [DATA_WIDTH-1:0]   inst_rdata,
    input  logic                    data_en,
    input  logic [DATA_WIDTH/8-1:0] data_wen,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [DATA_WIDTH/8-1:0] bus_sel,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_ack,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic                    stall_all,
    output logic                    bus_timeout
);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_WIDTH-1:0]   data_rdata_q, data_rdata_d;
    logic                    serve_data;
    logic                    req;
    logic                    to_hit;
    logic                    ack_eff;
    logic [DATA_WIDTH-1:0]   cap_data;

`ifdef BUS_TIMEOUT_EN
    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .wait_i (req && !bus_ack),
        .hit_o  (to_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign to_hit = 1'b0;
`endif

    // The request depends only on state and the frozen pipeline inputs, never on bus_ack.
    always_comb begin
        serve_data = (state_q == S_RUN) && data_en;
        req        = !rst && (((state_q == S_RUN) && (data_en || inst_en)) ||
                              (state_q == S_DDONE));
        ack_eff    = req && (bus_ack || to_hit);
        cap_data   = bus_ack ? bus_rdata : '0;
    end

    always_comb begin
        bus_req     = req;
        stall_all   = req;
        bus_timeout = to_hit;
        if (serve_data) begin
            bus_addr  = data_addr;
            bus_we    = |data_wen;
            bus_sel   = (|data_wen) ? data_wen : '1;
            bus_wdata = data_wdata;
        end else begin
            bus_addr  = inst_addr;
            bus_we    = 1'b0;
            bus_sel   = '1;
            bus_wdata = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        case (state_q)
            S_RUN: begin
                if (ack_eff) begin
                    if (data_en) begin
                        data_rdata_d = cap_data;
                        state_d      = inst_en ? S_DDONE : S_REL;
                    end else begin
                        inst_rdata_d = cap_data;
                        state_d      = S_REL;
                    end
                end
            end
            S_DDONE: begin
                if (ack_eff) begin
                    inst_rdata_d = cap_data;
                    state_d      = S_REL;
                end
            end
            S_REL:   state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RUN;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_stall_requester.sv
// Self-checking bench for mem_stall_requester: directed steps plus randomized steps
// checked against a per-step cycle plan kept in an expected queue.
module tb_mem_stall_requester;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_en;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          data_en;
    logic [SW-1:0] data_wen;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata;
    logic          bus_req;
    logic          bus_we;
    logic [SW-1:0] bus_sel;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;
    logic          stall_all;
    logic          bus_timeout;

    int n_vec = 0;
    int n_err = 0;

    // Architectural model: what each captured-data register must hold.
    logic [DW-1:0] m_inst;
    logic [DW-1:0] m_data;

    // One planned cycle: what the bus slave does and what the DUT must show.
    typedef struct {
        bit            stall;
        logic [AW-1:0] addr;
        bit            we;
        logic [SW-1:0] sel;
        logic [DW-1:0] wdata;
        bit            ack;
        logic [DW-1:0] rdata;
        bit            to;
    } cyc_t;
    cyc_t exp_q[$];

    mem_stall_requester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stall_all(stall_all), .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    // Drains the plan: drives the slave after each rising edge, checks at the falling edge.
    task automatic play_queue();
        cyc_t c;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            bus_ack   = c.ack;
            bus_rdata = c.rdata;
            @(negedge clk);
            n_vec++;
            if (stall_all !== c.stall) begin
                n_err++;
                $display("FAIL stall_all: got %b expected %b at %0t", stall_all, c.stall, $time);
            end
            n_vec++;
            if (bus_req !== c.stall) begin
                n_err++;
                $display("FAIL bus_req: got %b expected %b at %0t", bus_req, c.stall, $time);
            end
            n_vec++;
            if (bus_timeout !== c.to) begin
                n_err++;
                $display("FAIL bus_timeout: got %b expected %b at %0t", bus_timeout, c.to, $time);
            end
            if (c.stall) begin
                n_vec++;
                if ({bus_addr, bus_we, bus_sel, bus_wdata} !== {c.addr, c.we, c.sel, c.wdata}) begin
                    n_err++;
                    $display("FAIL bus_fields: got addr=%h we=%b sel=%b wdata=%h expected addr=%h we=%b sel=%b wdata=%h at %0t",
                             bus_addr, bus_we, bus_sel, bus_wdata, c.addr, c.we, c.sel, c.wdata, $time);
                end
            end else begin
                n_vec++;
                if (data_rdata !== m_data) begin
                    n_err++;
                    $display("FAIL data_rdata: got %h expected %h at %0t", data_rdata, m_data, $time);
                end
                n_vec++;
                if (inst_rdata !== m_inst) begin
                    n_err++;
                    $display("FAIL inst_rdata: got %h expected %h at %0t", inst_rdata, m_inst, $time);
                end
            end
            @(posedge clk);
            #1;
        end
        bus_ack = 1'b0;
    endtask

    // Plans one pipeline step: data phase (wd waits) then fetch phase (wi waits), then release.
    task automatic run_step(input bit den, input bit ien, input logic [SW-1:0] wen,
                            input logic [AW-1:0] daddr, input logic [DW-1:0] wdata,
                            input logic [AW-1:0] iaddr, input int wd, input int wi,
                            input bit data_times_out);
        cyc_t c;
        int   n;
        data_en    = den;
        inst_en    = ien;
        data_wen   = wen;
        data_addr  = daddr;
        data_wdata = wdata;
        inst_addr  = iaddr;
        if (den) begin
            n = data_times_out ? TO + 1 : wd + 1;
            for (int k = 0; k < n; k++) begin
                c.stall = 1'b1; c.addr = daddr; c.we = |wen;
                c.sel   = (|wen) ? wen : '1; c.wdata = wdata;
                c.ack   = !data_times_out && (k == n - 1);
                c.rdata = $urandom;
                c.to    = data_times_out && (k == n - 1);
                exp_q.push_back(c);
            end
            m_data = data_times_out ? '0 : c.rdata;
        end
        if (ien) begin
            for (int k = 0; k <= wi; k++) begin
                c.stall = 1'b1; c.addr = iaddr; c.we = 1'b0;
                c.sel   = '1; c.wdata = '0;
                c.ack   = (k == wi); c.rdata = $urandom; c.to = 1'b0;
                exp_q.push_back(c);
            end
            m_inst = c.rdata;
        end
        // Release (or idle) cycle: an ack here has no request behind it and must be ignored.
        c.stall = 1'b0; c.addr = '0; c.we = 1'b0; c.sel = '0; c.wdata = '0;
        c.ack   = 1'b1; c.rdata = $urandom; c.to = 1'b0;
        exp_q.push_back(c);
        play_queue();
    endtask

    task automatic test_reset();
        rst = 1'b1; data_en = 1'b1; inst_en = 1'b1; data_wen = '0;
        data_addr = 32'h40; inst_addr = 32'h80; data_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        m_inst = '0; m_data = '0;
        #3;
        n_vec++;
        if ({bus_req, stall_all, bus_timeout} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl: got req/stall/to=%b expected 000", {bus_req, stall_all, bus_timeout});
        end
        n_vec++;
        if ({inst_rdata, data_rdata} !== {2 * DW{1'b0}}) begin
            n_err++;
            $display("FAIL reset_rdata: got inst=%h data=%h expected 0", inst_rdata, data_rdata);
        end
        data_en = 1'b0; inst_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fetch_only();
        run_step(1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0000_0400, 0, 0, 1'b0);
        exp_q.delete();
        // Fixed capture value for the fetch: re-plan with a known bus word.
        inst_en = 1'b1; inst_addr = 32'h0000_0404; data_en = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h2402_0001;
        @(negedge clk);
        n_vec++;
        if (stall_all !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_stall_c1: got %b expected 1", stall_all);
        end
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if (stall_all !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_stall_c2: got %b expected 0", stall_all);
        end
        n_vec++;
        if (inst_rdata !== 32'h2402_0001) begin
            n_err++;
            $display("FAIL fetch_inst_rdata: got %h expected 24020001", inst_rdata);
        end
        m_inst = 32'h2402_0001;
        inst_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_fetch();
        run_step(1'b1, 1'b1, 4'b0000, 32'h0000_0100, 32'h1234_5678, 32'h0000_0200, 2, 2, 1'b0);
    endtask

    task automatic test_byte_store();
        run_step(1'b1, 1'b1, 4'b0001, 32'h0000_0104, 32'h0000_00AB, 32'h0000_0208, 1, 0, 1'b0);
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            run_step(1'b0, 1'b0, 4'b1111, $urandom, $urandom, $urandom, 0, 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_access();
        data_en = 1'b1; inst_en = 1'b1; data_wen = 4'b0000;
        data_addr = 32'h0000_0300; inst_addr = 32'h0000_0600; data_wdata = '0;
        bus_ack = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus_req, stall_all} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_mid_ctrl: got req/stall=%b expected 00", {bus_req, stall_all});
        end
        m_inst = '0;
        m_data = '0;
        @(negedge clk);
        n_vec++;
        if ({inst_rdata, data_rdata} !== {2 * DW{1'b0}}) begin
            n_err++;
            $display("FAIL reset_mid_rdata: got inst=%h data=%h expected 0", inst_rdata, data_rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_step(1'b1, 1'b1, 4'b0000, 32'h0000_0300, 32'h0, 32'h0000_0600, 1, 1, 1'b0);
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        run_step(1'b1, 1'b1, 4'b0000, 32'h0000_0500, 32'h0, 32'h0000_0700, 0, 1, 1'b1);
    endtask
`endif

    task automatic test_random();
        logic [SW-1:0] wen;
        for (int i = 0; i < 40; i++) begin
            wen = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
            run_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wen,
                     $urandom, $urandom, $urandom,
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_load_fetch();
        test_byte_store();
        test_idle();
        test_reset_mid_access();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
